arilla_bus_arbiter: RTL and testbench

//  Shares one arilla_bus among NumMasters masters (core mem_interface, debug system-bus master, ...).
//  The bus is tri-state. Each master drives it only while its inhibit input is low, so this block

---
 rtl/arilla_arb_pkg.sv | 39 +++
 rtl/arilla_arb_select.sv | 52 +++++
 rtl/arilla_bus_arbiter.sv | 114 +++++++++++
 tb/tb_arilla_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arilla_arb_pkg.sv
// Shared types, defaults and helpers for the arilla bus arbiter and its picker.
package arilla_arb_pkg;

    typedef enum logic {
        ARB_OWN  = 1'b0,
        ARB_TURN = 1'b1
    } arb_state_e;

    localparam int ARB_DEF_MASTERS  = 2;
    localparam int ARB_DEF_MAX_HOLD = 16;
    localparam int ARB_DEF_TURN     = 1;

    // The rotate helper works on a fixed-width vector so the package needs no parameters.
    localparam int ARB_MAX_MASTERS  = 32;
    localparam int ARB_IDX_W        = 5;

    // Bits needed for a counter running 0..max_val-1 (never less than one bit).
    function automatic int arb_cnt_width(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

    // Rotate the low n bits of vec right by shift (shift < n): result[k] = vec[(k+shift) mod n].
    function automatic logic [ARB_MAX_MASTERS-1:0] arb_rotate(
        input logic [ARB_MAX_MASTERS-1:0] vec,
        input int                         shift,
        input int                         n
    );
        logic [ARB_MAX_MASTERS-1:0] r;
        int j;
        r = '0;
        for (int i = 0; i < ARB_MAX_MASTERS; i++) begin
            j = i + shift;
            if (j >= n) j = j - n;
            if (i < n && j < ARB_MAX_MASTERS) r[i[ARB_IDX_W-1:0]] = vec[j[ARB_IDX_W-1:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/arilla_arb_select.sv
// Combinational winner picker for arilla_bus_arbiter.
// ARB_ROUND_ROBIN_EN defined: round-robin starting above last_owner; undefined: lowest index wins.
module arilla_arb_select
    import arilla_arb_pkg::*;
#(
    parameter int NumMasters = ARB_DEF_MASTERS
) (
    input  logic [NumMasters-1:0]         req,
    input  logic [$clog2(NumMasters)-1:0] last_owner,
    output logic [$clog2(NumMasters)-1:0] winner,
    output logic                          any
);

    localparam int OwnerW = $clog2(NumMasters);

    assign any = |req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ARB_MAX_MASTERS-1:0] req_ext;
    logic [ARB_MAX_MASTERS-1:0] rot;
    int                         start;
    int                         idx;

    // Rotate so the master just above last_owner sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_ext                 = '0;
        req_ext[NumMasters-1:0] = req;
        start                   = int'(last_owner) + 1;
        if (start >= NumMasters) start = 0;
        rot = arb_rotate(req_ext, start, NumMasters);
        idx = start;
        for (int k = NumMasters - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = start + k;
                if (idx >= NumMasters) idx = idx - NumMasters;
            end
        end
        winner = OwnerW'(idx);
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    always_comb begin
        winner = '0;
        for (int k = NumMasters - 1; k >= 0; k--) begin
            if (req[k]) winner = OwnerW'(k);
        end
    end
`endif

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Tri-state bus arbiter: one owner un-inhibited at a time, with an all-inhibited turnaround gap
// on every ownership change. Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module arilla_bus_arbiter
    import arilla_arb_pkg::*;
#(
    parameter int NumMasters = ARB_DEF_MASTERS,
    parameter int ParkMaster = 0,
    parameter int MaxHold    = ARB_DEF_MAX_HOLD,
    parameter int TurnCycles = ARB_DEF_TURN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumMasters-1:0]         req,
    input  logic [NumMasters-1:0]         lock,
    output logic [NumMasters-1:0]         inhibit,
    output logic [NumMasters-1:0]         grant,
    output logic [$clog2(NumMasters)-1:0] owner,
    output logic                          switching
);

    localparam int                    OwnerW   = $clog2(NumMasters);
    localparam int                    HoldW    = arb_cnt_width(MaxHold);
    localparam int                    TurnW    = arb_cnt_width(TurnCycles);
    localparam logic [OwnerW-1:0]     Park     = OwnerW'(ParkMaster);
    localparam logic [HoldW-1:0]      HoldLast = HoldW'((MaxHold == 0) ? 0 : MaxHold - 1);
    localparam logic [TurnW-1:0]      TurnLast = TurnW'(TurnCycles - 1);
    localparam logic [NumMasters-1:0] OneHot0  = NumMasters'(1);

    arb_state_e            state_q, state_d;
    logic [OwnerW-1:0]     owner_q, owner_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [TurnW-1:0]      turn_cnt_q, turn_cnt_d;
    logic [NumMasters-1:0] grant_q, grant_d;
    logic [NumMasters-1:0] inhibit_q, inhibit_d;
    logic                  switching_q, switching_d;

    logic [NumMasters-1:0] others;
    logic [OwnerW-1:0]     sel_winner;
    logic                  sel_any;
    logic                  own_req;
    logic                  own_lock;
    logic                  expired;
    logic                  keep;

    assign others   = req & ~(OneHot0 << owner_q);
    assign own_req  = req[owner_q];
    assign own_lock = lock[owner_q];
    assign expired  = (MaxHold != 0) && (hold_cnt_q == HoldLast) && sel_any && !own_lock;
    assign keep     = (own_req || own_lock) && !expired;

    arilla_arb_select #(
        .NumMasters (NumMasters)
    ) u_select (
        .req        (others),
        .last_owner (owner_q),
        .winner     (sel_winner),
        .any        (sel_any)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        case (state_q)
            ARB_OWN: begin
                if (own_req && hold_cnt_q != HoldLast) hold_cnt_d = hold_cnt_q + 1'b1;
                // Nobody else waiting and already parked: nothing to hand over.
                if (!keep && (sel_any || owner_q != Park)) begin
                    state_d    = ARB_TURN;
                    owner_d    = sel_any ? sel_winner : Park;
                    hold_cnt_d = '0;
                    turn_cnt_d = TurnLast;
                end
            end
            ARB_TURN: begin
                if (turn_cnt_q == '0) state_d = ARB_OWN;
                else                  turn_cnt_d = turn_cnt_q - 1'b1;
            end
            default: state_d = ARB_OWN;
        endcase
        // Outputs are registered copies of the next state so they never glitch.
        grant_d     = (state_d == ARB_OWN) ? (OneHot0 << owner_d) : '0;
        inhibit_d   = ~grant_d;
        switching_d = (state_d == ARB_TURN);
    end

    // Reset drops the current owner immediately; no turnaround is inserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_OWN;
            owner_q     <= Park;
            hold_cnt_q  <= '0;
            turn_cnt_q  <= '0;
            grant_q     <= OneHot0 << Park;
            inhibit_q   <= ~(OneHot0 << Park);
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            grant_q     <= grant_d;
            inhibit_q   <= inhibit_d;
            switching_q <= switching_d;
        end
    end

    assign grant     = grant_q;
    assign inhibit   = inhibit_q;
    assign owner     = owner_q;
    assign switching = switching_q;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Scoreboard bench for arilla_bus_arbiter: directed scenarios plus randomized traffic on two
// configurations, checked every cycle against a behavioural model of the arbitration rules.
module tb_arilla_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req_a, lock_a, inh_a, gnt_a;
    logic       own_a, sw_a;
    logic [2:0] req_b, lock_b, inh_b, gnt_b;
    logic [1:0] own_b;
    logic       sw_b;

    arilla_bus_arbiter #(.NumMasters(2), .ParkMaster(0), .MaxHold(4), .TurnCycles(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .lock(lock_a),
        .inhibit(inh_a), .grant(gnt_a), .owner(own_a), .switching(sw_a));

    arilla_bus_arbiter #(.NumMasters(3), .ParkMaster(2), .MaxHold(3), .TurnCycles(2)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .lock(lock_b),
        .inhibit(inh_b), .grant(gnt_b), .owner(own_b), .switching(sw_b));

    // Model: who owns (or is about to own) the bus, whether we are in the gap and for how long.
    typedef struct {
        bit valid;
        bit turning;
        int owner;
        int held;
        int left;
    } mdl_t;

    typedef struct {
        int grant;
        int inhibit;
        int owner;
        bit sw;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];
    mdl_t ma, mb;

    function automatic int pick(int cand, int last, int n);
        int c;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= n; k++) begin
            c = (last + k) % n;
            if (cand[c]) return c;
        end
`else
        for (c = 0; c < n; c++) if (cand[c]) return c;
`endif
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t s, int n, int park, int maxh, int turns,
                                  bit r, int rq, int lk);
        mdl_t t;
        int   others, nxt;
        bit   keep, expired;
        t = s;
        if (r) begin
            t.valid = 1; t.turning = 0; t.owner = park; t.held = 0; t.left = 0;
            return t;
        end
        if (!s.valid) return t;
        if (s.turning) begin
            t.left = s.left - 1;
            if (t.left == 0) t.turning = 0;
            return t;
        end
        others  = rq & ~(1 << s.owner);
        expired = (maxh != 0) && (s.held == maxh - 1) && (others != 0) && !lk[s.owner];
        keep    = (rq[s.owner] || lk[s.owner]) && !expired;
        if (rq[s.owner] && s.held < maxh - 1) t.held = s.held + 1;
        nxt = -1;
        if (!keep) begin
            if (others != 0)          nxt = pick(others, s.owner, n);
            else if (s.owner != park) nxt = park;
        end
        if (nxt >= 0) begin
            t.turning = 1; t.owner = nxt; t.held = 0; t.left = turns;
        end
        return t;
    endfunction

    function automatic exp_t expect_of(mdl_t s, int n);
        exp_t e;
        e.grant   = s.turning ? 0 : (1 << s.owner);
        e.inhibit = ~e.grant & ((1 << n) - 1);
        e.owner   = s.owner;
        e.sw      = s.turning;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input int g, input int inh,
                       input int own, input bit sw);
        checks++;
        if (g != e.grant || inh != e.inhibit || own != e.owner || sw != e.sw) begin
            errors++;
            $display("FAIL %s @%0t: got grant=%0h inhibit=%0h owner=%0d switching=%0d, expected grant=%0h inhibit=%0h owner=%0d switching=%0d",
                     nm, $time, g, inh, own, sw, e.grant, e.inhibit, e.owner, e.sw);
        end
    endtask

    // Drive one cycle's inputs just after the edge; record what the DUT should show now.
    task automatic cyc(input bit r, input int ra, input int la, input int rb, input int lb);
        @(posedge clk);
        #1;
        rst    = r;
        req_a  = 2'(ra);
        lock_a = 2'(la);
        req_b  = 3'(rb);
        lock_b = 3'(lb);
        if (ma.valid) qa.push_back(expect_of(ma, 2));
        if (mb.valid) qb.push_back(expect_of(mb, 3));
        ma = step(ma, 2, 0, 4, 1, r, ra & 3, la & 3);
        mb = step(mb, 3, 2, 3, 2, r, rb & 7, lb & 7);
    endtask

    task automatic cyc_a(input bit r, input int ra, input int la);
        cyc(r, ra, la, 0, 0);
    endtask

    // Monitor: outputs are registered, so compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("arb_a", e, int'(gnt_a), int'(inh_a), int'(own_a), sw_a);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("arb_b", e, int'(gnt_b), int'(inh_b), int'(own_b), sw_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int ra, la, rb, lb, bad, run, max01, max10, prev;
        ma = '{default: 0};
        mb = '{default: 0};
        rst = 1'b1; req_a = '0; lock_a = '0; req_b = '0; lock_b = '0;

        // Reset with master 1 already requesting, then the first handover.
        cyc_a(1, 2'b10, 0);
        cyc_a(1, 2'b10, 0);
        chk("reset_grant", int'(gnt_a), 1);
        chk("reset_inhibit", int'(inh_a), 2);
        cyc_a(0, 2'b10, 0);
        chk("release_grant", int'(gnt_a), 1);
        chk("release_owner", int'(own_a), 0);
        cyc_a(0, 2'b10, 0);
        chk("first_turn_grant", int'(gnt_a), 0);
        chk("first_turn_switching", int'(sw_a), 1);
        cyc_a(0, 2'b10, 0);
        chk("first_switch_grant", int'(gnt_a), 2);

        // Park: owner 1 drops its request.
        cyc_a(0, 2'b00, 0);
        cyc_a(0, 2'b00, 0);
        chk("park_turn_inhibit", int'(inh_a), 3);
        cyc_a(0, 2'b00, 0);
        chk("park_grant", int'(gnt_a), 1);
        cyc_a(0, 2'b00, 0);
        chk("parked_no_turn", int'(sw_a), 0);

        // Handover: req 01 -> 11, then req[0] falls at t.
        cyc_a(0, 2'b01, 0);
        cyc_a(0, 2'b11, 0);
        cyc_a(0, 2'b10, 0);
        cyc_a(0, 2'b10, 0);
        chk("handover_t1_grant", int'(gnt_a), 0);
        chk("handover_t1_inhibit", int'(inh_a), 3);
        cyc_a(0, 2'b10, 0);
        chk("handover_t2_grant", int'(gnt_a), 2);
        chk("handover_t2_inhibit", int'(inh_a), 1);

        // MaxHold=4 with both requesting: runs of exactly four owned cycles.
        run = 0; max01 = 0; max10 = 0; prev = -1;
        for (int i = 0; i < 24; i++) begin
            cyc_a(0, 2'b11, 0);
            run  = (int'(gnt_a) == prev) ? run + 1 : 1;
            prev = int'(gnt_a);
            if (gnt_a == 2'b01 && run > max01) max01 = run;
            if (gnt_a == 2'b10 && run > max10) max10 = run;
        end
        chk("maxhold_run_m0", max01, 4);
        chk("maxhold_run_m1", max10, 4);

        // Lock held by owner 1 for 40 cycles (last 10 without its request).
        for (int i = 0; i < 12 && gnt_a != 2'b10; i++) cyc_a(0, 2'b11, 0);
        chk("lock_setup_owner1", int'(gnt_a), 2);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc_a(0, (i < 30) ? 2'b11 : 2'b01, 2'b10);
            if (i > 0 && gnt_a != 2'b10) bad++;
        end
        chk("lock_hold_bad_cycles", bad, 0);
        cyc_a(0, 2'b11, 0);
        chk("lock_drop_still_owned", int'(gnt_a), 2);
        cyc_a(0, 2'b01, 0);
        chk("lock_drop_turn", int'(sw_a), 1);
        cyc_a(0, 2'b01, 0);

        // Reset during a turnaround heading to master 1.
        cyc_a(0, 2'b10, 0);
        chk("pre_midturn_grant", int'(gnt_a), 1);
        cyc_a(1, 2'b10, 0);
        chk("midturn_switching", int'(sw_a), 1);
        cyc_a(0, 2'b00, 0);
        chk("midturn_reset_grant", int'(gnt_a), 1);
        chk("midturn_reset_switching", int'(sw_a), 0);

        // Randomized traffic on both configurations; requests and locks are sticky.
        ra = 0; la = 0; rb = 0; lb = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) ra = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rb = int'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) la = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0;
            if ($urandom_range(0, 15) == 0) lb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
            cyc($urandom_range(0, 249) == 0, ra, la, rb, lb);
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", qa.size() + qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
